vanilla_barrier_relay: RTL and testbench

//  Per-tile barrier network node; the network-side counterpart of the core CSR barrier registers.

---
 rtl/vanilla_barrier_relay_if.sv | 14 +
 rtl/vanilla_barrier_relay.sv | 99 +++++++++
 tb/tb_vanilla_barrier_relay.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/vanilla_barrier_relay_if.sv
// vanilla_barrier_relay_if: core CSR and inter-tile barrier wires of one relay node.
interface vanilla_barrier_relay_if #(parameter int barrier_dirs_p = 7);
    localparam int barrier_lg_dirs_lp = $clog2(barrier_dirs_p + 1);
    logic                          pi_i;
    logic                          po_o;
    logic [barrier_dirs_p-1:0]     src_i;
    logic [barrier_lg_dirs_lp-1:0] dest_i;
    logic [barrier_dirs_p-1:0]     up_i;
    logic [barrier_dirs_p-1:0]     up_o;
    logic [barrier_dirs_p-1:0]     dn_i;
    logic [barrier_dirs_p-1:0]     dn_o;
    modport slave (input pi_i, src_i, dest_i, up_i, dn_i, output po_o, up_o, dn_o);
    modport master (output pi_i, src_i, dest_i, up_i, dn_i, input po_o, up_o, dn_o);
endinterface

// File: rtl/vanilla_barrier_relay.sv
// vanilla_barrier_relay: per-tile barrier gather/release node between the core CSR block and neighbours.
// Optional VANILLA_BARRIER_RELAY_PERF_EN adds perf_done_o / perf_wait_o counters.
module vanilla_barrier_relay #(
    parameter int barrier_dirs_p = 7
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    vanilla_barrier_relay_if.slave bar
`ifdef VANILLA_BARRIER_RELAY_PERF_EN
    ,
    output logic [31:0]            perf_done_o,
    output logic [31:0]            perf_wait_o
`endif
);
    localparam int barrier_lg_dirs_lp = $clog2(barrier_dirs_p + 1);
    localparam int pad_lp = (1 << barrier_lg_dirs_lp) - barrier_dirs_p;

    typedef enum logic [1:0] {IDLE = 2'd0, GATHER = 2'd1, WAIT = 2'd2} state_e;

    state_e                        state_r, state_n;
    logic                          po_r, po_n;
    logic                          up_val_r, up_val_n;
    logic [barrier_dirs_p-1:0]     in_r, dn_r, src_r;
    logic [barrier_lg_dirs_lp-1:0] dest_r;
    logic                          target, all_m, any_m, root;
    logic [barrier_dirs_p-1:0]     match;
    logic [(1<<barrier_lg_dirs_lp)-1:0] dn_pad;

    assign target = ~po_r;
    assign match  = in_r ~^ {barrier_dirs_p{target}};
    assign all_m  = (|src_r) & (&(~src_r | match));
    assign any_m  = |(src_r & match);
    assign root   = (dest_r == '0) | (32'(dest_r) >= barrier_dirs_p);
    // Padding keeps the dest index in range for the unused encodings above the last direction.
    assign dn_pad = {{pad_lp{1'b0}}, dn_r};

    always_comb begin
        state_n  = state_r;
        po_n     = po_r;
        up_val_n = up_val_r;
        case (state_r)
            IDLE, GATHER: begin
                if (all_m) begin
                    up_val_n = target;
                    po_n     = root ? target : po_r;
                    state_n  = root ? IDLE : WAIT;
                end else if (any_m) begin
                    state_n = GATHER;
                end
            end
            WAIT: begin
                if (dn_pad[dest_r] == up_val_r) begin
                    po_n    = up_val_r;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Config only follows barcfg while idle, so an in-flight barrier keeps the config it started with.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            po_r     <= 1'b0;
            up_val_r <= 1'b0;
            in_r     <= '0;
            dn_r     <= '0;
            src_r    <= '0;
            dest_r   <= '0;
        end else begin
            state_r  <= state_n;
            po_r     <= po_n;
            up_val_r <= up_val_n;
            in_r     <= {bar.up_i[barrier_dirs_p-1:1], bar.pi_i};
            dn_r     <= bar.dn_i;
            if (state_r == IDLE && state_n == IDLE) begin
                src_r  <= bar.src_i;
                dest_r <= bar.dest_i;
            end
        end
    end

    assign bar.po_o = po_r;
    assign bar.up_o = root ? '0 : ({{(barrier_dirs_p-1){1'b0}}, up_val_r} << dest_r);
    assign bar.dn_o = {src_r[barrier_dirs_p-1:1] & {(barrier_dirs_p-1){po_r}}, 1'b0};

`ifdef VANILLA_BARRIER_RELAY_PERF_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_done_o <= '0;
            perf_wait_o <= '0;
        end else begin
            perf_done_o <= perf_done_o + {31'd0, po_n != po_r};
            perf_wait_o <= perf_wait_o + {31'd0, state_r != IDLE};
        end
    end
`endif
endmodule

// File: tb/tb_vanilla_barrier_relay.sv
// tb_vanilla_barrier_relay: directed self-checking bench for the barrier relay node.
module tb_vanilla_barrier_relay;
    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    int checks = 0;
    int failures = 0;

    vanilla_barrier_relay_if bif ();
`ifdef VANILLA_BARRIER_RELAY_PERF_EN
    logic [31:0] perf_done_o, perf_wait_o;
`endif

    vanilla_barrier_relay dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .bar(bif)
`ifdef VANILLA_BARRIER_RELAY_PERF_EN
        ,
        .perf_done_o(perf_done_o),
        .perf_wait_o(perf_wait_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        bif.pi_i = 0; bif.src_i = 0; bif.dest_i = 0; bif.up_i = 0; bif.dn_i = 0;
        #12;
        check("rst_po", 32'(bif.po_o), 0);
        check("rst_up", 32'(bif.up_o), 0);
        check("rst_dn", 32'(bif.dn_o), 0);
        check("rst_state", 32'(dut.state_r), 0);
        tick(1);
        reset_i = 0;
        bif.src_i = 7'b000_0001; bif.dest_i = 0;
        tick(2);
        bif.pi_i = 1;
        tick(1);
        check("root_po_t1", 32'(bif.po_o), 0);
        tick(1);
        check("root_po_t2", 32'(bif.po_o), 1);
        check("root_dn", 32'(bif.dn_o), 0);
        check("root_up", 32'(bif.up_o), 0);
        bif.pi_i = 0;
        tick(1);
        check("root_rev_t1", 32'(bif.po_o), 1);
        tick(1);
        check("root_rev_t2", 32'(bif.po_o), 0);

        bif.src_i = 7'b000_0011; bif.dest_i = 2;
        tick(2);
        bif.pi_i = 1; bif.up_i = 7'b000_0010;
        tick(1);
        check("nr_up_t1", 32'(bif.up_o), 0);
        tick(1);
        check("nr_up_t2", 32'(bif.up_o), 32'b100);
        check("nr_state", 32'(dut.state_r), 2);
        check("nr_po_hold", 32'(bif.po_o), 0);
        bif.dn_i = 7'b000_0100;
        tick(1);
        check("nr_po_t1", 32'(bif.po_o), 0);
        tick(1);
        check("nr_po_t2", 32'(bif.po_o), 1);
        check("nr_dn", 32'(bif.dn_o), 32'b10);
        check("nr_idle", 32'(dut.state_r), 0);
        bif.pi_i = 0; bif.up_i = 0;
        tick(2);
        check("nr_up_low", 32'(bif.up_o), 0);
        bif.dn_i = 0;
        tick(2);
        check("nr_rev_po", 32'(bif.po_o), 0);
        check("nr_rev_dn", 32'(bif.dn_o), 0);

        bif.pi_i = 1;
        tick(20);
        check("part_state", 32'(dut.state_r), 1);
        check("part_up", 32'(bif.up_o), 0);
        bif.src_i = 7'b000_0001; bif.dest_i = 0;
        tick(3);
        check("part_frozen", 32'(dut.state_r), 1);
        check("part_po", 32'(bif.po_o), 0);
        bif.up_i = 7'b000_0010;
        tick(2);
        check("part_wait", 32'(dut.state_r), 2);
        check("part_up_done", 32'(bif.up_o), 32'b100);

        #2 reset_i = 1;
        #1;
        check("arst_po", 32'(bif.po_o), 0);
        check("arst_up", 32'(bif.up_o), 0);
        check("arst_dn", 32'(bif.dn_o), 0);
        check("arst_state", 32'(dut.state_r), 0);
        tick(1);
        reset_i = 0;
        tick(2);
        check("post_rst_po", 32'(bif.po_o), 1);
        bif.pi_i = 0;
        tick(2);
        check("post_rst_rev", 32'(bif.po_o), 0);

        bif.src_i = 7'b000_0011; bif.dest_i = 0; bif.up_i = 0;
        tick(2);
        bif.pi_i = 1;
        tick(10);
        check("child_miss_po", 32'(bif.po_o), 0);
        check("child_miss_st", 32'(dut.state_r), 1);
        reset_i = 1;
        bif.src_i = 0; bif.pi_i = 0;
        tick(1);
        reset_i = 0;
        tick(2);
        bif.pi_i = 1; bif.up_i = 7'b111_1110;
        tick(5);
        check("inert_state", 32'(dut.state_r), 0);
        check("inert_po", 32'(bif.po_o), 0);

`ifdef VANILLA_BARRIER_RELAY_PERF_EN
        reset_i = 1;
        bif.pi_i = 0; bif.up_i = 0; bif.dn_i = 0; bif.src_i = 7'b000_0001; bif.dest_i = 0;
        tick(1);
        reset_i = 0;
        tick(2);
        bif.pi_i = 1; tick(2);
        bif.pi_i = 0; tick(2);
        bif.pi_i = 1; tick(2);
        check("perf_done3", perf_done_o, 3);
        check("perf_wait0", perf_wait_o, 0);
        bif.src_i = 7'b000_0011; bif.dest_i = 2; bif.pi_i = 0; bif.dn_i = 7'b000_0100;
        tick(7);
        check("perf_wait5", perf_wait_o, 5);
        bif.dn_i = 0;
        tick(2);
        check("perf_wait7", perf_wait_o, 7);
        check("perf_done4", perf_done_o, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
